// File: rtl/muldiv4_pkg.sv
// ============================================================================
// Module   : muldiv4_pkg
// Brief    : Shared types and constants for the muldiv4 datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv4_pkg;

  localparam int MULDIV4_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv4_div_step.sv
// ============================================================================
// Module   : muldiv4_div_step
// Brief    : One combinational restoring-division step (shift, trial, select).
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv4_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {rem_in, bit_in};
  assign w_trial   = w_shifted - {1'b0, divisor};

  // On restore the shifted value is below the divisor, so it fits in WIDTH bits.
  assign q_bit   = (w_shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/muldiv4_seq_div.sv
// ============================================================================
// Module   : muldiv4_seq_div
// Brief    : Sequential restoring divider, one quotient bit per clock.
//            Optional signed support via MULDIV4_SIGNED_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv4_seq_div
  import muldiv4_pkg::*;
#(
  parameter int WIDTH = MULDIV4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MULDIV4_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int               c_cnt_w = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ones  = {WIDTH{1'b1}};

  state_t             r_state;
  state_t             w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_q_raw;
  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic               w_last;

`ifdef MULDIV4_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg = signed_op & dividend[WIDTH-1];
  assign w_dvs_neg = signed_op & divisor[WIDTH-1];
  // Most-negative magnitude is representable as an unsigned WIDTH-bit value.
  assign w_dvd_mag = w_dvd_neg ? (~dividend + c_one) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + c_one) : divisor;
  assign w_q_final = r_neg_q ? (~w_q_raw + c_one) : w_q_raw;
  assign w_r_final = r_neg_r ? (~w_step_rem + c_one) : w_step_rem;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_final = w_q_raw;
  assign w_r_final = w_step_rem;
`endif

  muldiv4_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_dvd[WIDTH-1]),
    .divisor (r_dvs),
    .rem_out (w_step_rem),
    .q_bit   (w_step_q)
  );

  // Dividend register doubles as the quotient shift register.
  assign w_q_raw = {r_dvd[WIDTH-2:0], w_step_q};
  assign w_last  = (r_cnt == c_cnt_w'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (divisor == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef MULDIV4_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= c_ones;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_dvd <= w_dvd_mag;
              r_dvs <= w_dvs_mag;
              r_rem <= '0;
              r_cnt <= c_cnt_w'(WIDTH);
`ifdef MULDIV4_SIGNED_EN
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
`endif
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_dvd <= w_q_raw;
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (w_last) begin
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dbz       = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv4_seq_div.sv
// ============================================================================
// Module   : tb_muldiv4_seq_div
// Brief    : Directed self-checking bench for muldiv4_seq_div (WIDTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv4_seq_div;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
`ifdef MULDIV4_SIGNED_EN
  logic         signed_op;
`endif

  int checks   = 0;
  int failures = 0;

  muldiv4_seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef MULDIV4_SIGNED_EN
    .signed_op (signed_op),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next edge and check the full timeline of the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    if (b != '0) begin
      for (int k = 1; k <= W; k++) begin
        check({tag, ".done_early"}, 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
      end
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".q"},    32'(quotient), 32'(eq));
    check({tag, ".r"},    32'(remainder), 32'(er));
    check({tag, ".dbz"},  32'(dbz), 32'(ed));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".done_clr"}, 32'(done), 32'd0);
    check({tag, ".busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef MULDIV4_SIGNED_EN
    signed_op = 1'b0;
`endif
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.q",    32'(quotient), 32'd0);
    check("rst.r",    32'(remainder), 32'd0);
    check("rst.dbz",  32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    run_op("div7_0",  4'd7,  4'd0, 4'd15, 4'd7, 1'b1);

    // 15/1 with a competing 9/2 held on start through the busy window
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd9; divisor = 4'd2;
    for (int k = 1; k < W; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_ign.done_early", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("busy_ign.done", 32'(done), 32'd1);
    check("busy_ign.q",    32'(quotient), 32'd15);
    check("busy_ign.r",    32'(remainder), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_ign.idle", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("busy_ign.noq_busy", 32'(busy), 32'd0);
    end
    check("busy_ign.hold_q", 32'(quotient), 32'd15);
    check("busy_ign.hold_r", 32'(remainder), 32'd0);

    // Abort mid-CALC with asynchronous reset
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.q",    32'(quotient), 32'd0);
    check("abort.r",    32'(remainder), 32'd0);
    check("abort.dbz",  32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort.no_done", 32'(done), 32'd0);
    end
    run_op("div9_2",   4'd9,  4'd2,  4'd4, 4'd1, 1'b0);
    run_op("div2_5",   4'd2,  4'd5,  4'd0, 4'd2, 1'b0);
    run_op("div15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run_op("div0_7",   4'd0,  4'd7,  4'd0, 4'd0, 1'b0);

`ifdef MULDIV4_SIGNED_EN
    signed_op = 1'b1;
    run_op("sdiv_m7_2",  4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0);
    run_op("sdiv_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0);
    signed_op = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv4_seq_div.md
# muldiv4_seq_div

Sequential restoring divider for the muldiv4 datapath. It is the inverse-direction companion to the combinational multiply path: it takes a dividend and a divisor and produces a quotient and a remainder, one quotient bit per clock. A start/busy/done handshake connects it to the muldiv4 top-level operand and result registers.

## Interface
- `WIDTH`, default 4: operand, quotient and remainder width in bits. Must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe. Sampled only in IDLE.
- `dividend`  in  WIDTH  captured on the accepting edge.
- `divisor`  in  WIDTH  captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until the return to IDLE.
- `done`  out  1  one-cycle pulse; results are valid while it is high.
- `quotient`  out  WIDTH  registered result, held until the next accepted start.
- `remainder`  out  WIDTH  registered result, held until the next accepted start.
- `dbz`  out  1  divide-by-zero flag for the last operation, held with the results.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC when `start`=1 and `divisor`≠0. Operands are captured, the iteration counter is loaded with WIDTH, and the partial remainder is cleared.
- IDLE → DONE when `start`=1 and `divisor`=0. The FSM skips CALC and loads `quotient`=all ones, `remainder`=`dividend`, `dbz`=1.
- CALC step, once per cycle:
  - shift {partial remainder, dividend} left by 1;
  - trial = partial remainder − divisor, computed at WIDTH+1 bits;
  - if trial ≥ 0, keep the trial value and set the quotient LSB to 1; otherwise restore the remainder and set the quotient LSB to 0.
  - Decrement the counter. When the counter reaches 0, load the result registers, clear `dbz`, and go to DONE.
- DONE → IDLE unconditionally after one cycle.
- `start` is ignored whenever `busy`=1, including the DONE cycle. It is not queued.
- All arithmetic is unsigned unless the signed build is enabled (see Configuration). The remainder is always < divisor.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dbz`=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced and the results are cleared.
- Normal latency:
  - start accepted at edge 0;
  - CALC covers edges 1..WIDTH;
  - DONE state and `done`=1 follow edge WIDTH;
  - IDLE follows edge WIDTH+1.
  - For WIDTH=4, `done` is high in the cycle after edge 4.
- Divide-by-zero latency: `done`=1 in the cycle after edge 0.
- `busy`=1 in every non-IDLE state. `busy` and `done` change only on clock edges.
- A new start may be accepted on the edge at which the FSM leaves DONE only if it is still asserted in IDLE, i.e. at edge WIDTH+2 at the earliest. Back-to-back throughput is therefore WIDTH+2 cycles.

## Configuration
- `MULDIV4_SIGNED_EN` not defined: unsigned division only. Port list as above.
- `MULDIV4_SIGNED_EN` defined:
  - Adds input `signed_op` (1 bit), captured with the operands.
  - When `signed_op`=1, operands are two's complement. Magnitudes are divided, then results are sign-corrected when loading the result registers, so latency is unchanged.
  - Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Most-negative ÷ −1 returns quotient = most-negative (wrap) and remainder 0, with `dbz`=0.
  - Divide-by-zero returns quotient all ones, remainder = dividend.

## Structure
- Package `muldiv4_pkg`:
  - FSM state enum (IDLE/CALC/DONE);
  - `MULDIV4_WIDTH` constant, value 4;
  - counter-width function clog2(WIDTH+1).
- Sub-module `muldiv4_div_step`: purely combinational restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once and reused every cycle.

## Test plan
- 13 ÷ 3, WIDTH=4 → `done` in the cycle after edge 4; `quotient`=4, `remainder`=1, `dbz`=0, `busy` low after edge 5.
- 7 ÷ 0 → `done` in the cycle after edge 0; `quotient`=15, `remainder`=7, `dbz`=1.
- 15 ÷ 1, then `start` re-asserted while `busy` with 9 ÷ 2 → second request ignored; `quotient`=15, `remainder`=0; results held afterwards.
- 9 ÷ 2 started, `rst_n` pulsed low during CALC → no `done`; all outputs 0; a following 9 ÷ 2 yields `quotient`=4, `remainder`=1.
- 2 ÷ 5 → `quotient`=0, `remainder`=2; then 15 ÷ 15 → `quotient`=1, `remainder`=0.
- Signed build, −7 ÷ 2 → `quotient`=4'b1101 (−3), `remainder`=4'b1111 (−1); −8 ÷ −1 → `quotient`=4'b1000, `remainder`=0.
